lc3_regfile: RTL and testbench
==============================

# lc3_regfile

LC-3 general-purpose register file with condition-code and branch-enable registers, sitting directly upstream of the LC-3 ALU. It holds R0–R7 and drives the ALU's two register operands: SR1 goes to the ALU pass/first operand, and SR2 goes to the register-side input of the ALU's SR2 mux. It also captures the bus writeback value, derives the N/Z/P condition codes from that value, and latches BEN for the control unit.

## Interface
- `clk` input 1: single system clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `sr1_sel` input 3: SR1 register address.
- `sr2_sel` input 3: SR2 register address.
- `sr1_data` output 16: contents of R[`sr1_sel`]; feeds the ALU first/pass operand.
- `sr2_data` output 16: contents of R[`sr2_sel`]; feeds the ALU register-side SR2 input.
- `ld_reg` input 1: write enable for the register file.
- `dr_sel` input 3: destination register address.
- `bus_in` input 16: writeback value (ALU result or other bus source).
- `ld_cc` input 1: load enable for the condition codes.
- `nzp` output 3: condition codes {N,Z,P}.
- `ld_ben` input 1: load enable for BEN.
- `ir_nzp` input 3: branch mask, IR[11:9].
- `ben` output 1: registered branch enable.

## Operation
- Storage: eight 16-bit registers.
- Reads are combinational.
- Write: on a rising edge with `ld_reg`=1, R[`dr_sel`] takes `bus_in`. `ld_reg`=0 leaves all registers unchanged.
- CC generation (combinational from `bus_in`):
  - N = `bus_in`[15].
  - Z = (`bus_in` == 0).
  - P = ~N & ~Z.
  - Exactly one bit is set, always.
- CC register: on a rising edge with `ld_cc`=1, `nzp` takes the generated value. Otherwise it holds.
- BEN: on a rising edge with `ld_ben`=1, `ben` takes |(`ir_nzp` & `nzp`), using the registered `nzp` value before that edge.
- Simultaneous events:
  - `ld_reg` + `ld_cc` in the same cycle: both update from the same `bus_in`.
  - `ld_cc` + `ld_ben` in the same cycle: BEN uses the old `nzp`.
  - `sr1_sel` == `sr2_sel`: both outputs return the same value.
  - Read of `dr_sel` while `ld_reg`=1: behaviour is set by the configuration macro.
- All register addresses are valid; there is no out-of-range case.
- Reset, asynchronous, any time including mid-write:
  - R0–R7 = 16'h0000.
  - `nzp` = 3'b010 (Z).
  - `ben` = 0.
  - Reset overrides any concurrent load.

## Timing
- Read latency: 0 cycles (combinational from `sr*_sel` and stored state).
- Write latency: 1 edge. The value is visible on a read port after the edge following `ld_reg`=1.
- `nzp` and `ben` are visible after their load edge.
- No handshakes; the control unit guarantees load strobes are single-cycle per microstate.
- Outputs at reset: `sr1_data` = `sr2_data` = 16'h0000, `nzp` = 3'b010, `ben` = 0.

## Configuration
- Macro: `LC3_REGFILE_BYPASS_EN`.
- With the macro defined:
  - When `ld_reg`=1 and `sr1_sel` (or `sr2_sel`) == `dr_sel`, the corresponding read port returns `bus_in` combinationally in the same cycle (write-through forwarding).
  - No other behaviour changes.
- Without the macro: read ports always return stored state. Same-cycle reads of `dr_sel` return the pre-write value.
- Caution: with bypass enabled, a combinational loop exists if `bus_in` is driven combinationally from the ALU output, which is itself fed by `sr*_data`. Integration must break that path; it is only legal when `bus_in` is registered or sourced elsewhere.

## Structure
- Shared package `lc3_pkg` holds:
  - Constants `LC3_WORD_W`=16 and `LC3_REG_AW`=3.
  - NZP bit indices `NZP_N`=2, `NZP_Z`=1, `NZP_P`=0.
  - Reset constant `LC3_CC_RESET`=3'b010.
- One sub-module is natural: `lc3_cc_gen`, a combinational block mapping 16-bit `bus_in` to a 3-bit one-hot NZP, reused by other writeback paths.

## Test plan
- Reset check: hold `rst_n`=0, then release. All 8 registers read 16'h0000, `nzp`=3'b010, `ben`=0. Then assert `rst_n`=0 mid-cycle with `ld_reg`=1: registers clear immediately.
- Write/read: write R3=16'h1234 and R5=16'hFFFF, then read `sr1_sel`=3 and `sr2_sel`=5. Outputs are 16'h1234 and 16'hFFFF; no other register changes.
- CC generation: `ld_cc` with `bus_in`=16'h8000 → `nzp`=100. With 16'h0000 → 010. With 16'h7FFF → 001.
- BEN ordering: `nzp`=001 and `ir_nzp`=001 with `ld_ben` → `ben`=1. In the same cycle as `ld_cc` with `bus_in`=16'h0000, `ld_ben` with `ir_nzp`=010 → `ben`=0 (uses the old P), and `nzp` becomes 010.
- Same-cycle read-of-write: R2=16'h0005, then `ld_reg` with `dr_sel`=2, `bus_in`=16'h00AA, `sr1_sel`=2. With bypass, `sr1_data`=16'h00AA in that cycle; without, 16'h0005. After the edge it is 16'h00AA in both builds.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 constants and word/address types used by the register file
// and the other writeback-path blocks.
package lc3_pkg;

    localparam int unsigned LC3_WORD_W   = 16;
    localparam int unsigned LC3_REG_AW   = 3;
    localparam int unsigned LC3_NUM_REGS = 1 << LC3_REG_AW;

    // Bit positions inside the {N,Z,P} condition-code vector
    localparam int unsigned NZP_N = 2;
    localparam int unsigned NZP_Z = 1;
    localparam int unsigned NZP_P = 0;

    localparam logic [2:0] LC3_CC_RESET = 3'b010;

    typedef logic [LC3_WORD_W-1:0] word_t;
    typedef logic [LC3_REG_AW-1:0] reg_addr_t;
    typedef logic [2:0]            nzp_t;

endpackage

// File: rtl/lc3_regfile_if.sv
// Register-file port bundle: read addresses/data, writeback bus and the
// load strobes driven by the control unit.
interface lc3_regfile_if
    import lc3_pkg::*;
();
    reg_addr_t sr1_sel;
    reg_addr_t sr2_sel;
    word_t     sr1_data;
    word_t     sr2_data;
    logic      ld_reg;
    reg_addr_t dr_sel;
    word_t     bus_in;
    logic      ld_cc;
    nzp_t      nzp;
    logic      ld_ben;
    nzp_t      ir_nzp;
    logic      ben;

    // Control-unit / datapath side
    modport master (
        output sr1_sel, sr2_sel, ld_reg, dr_sel, bus_in, ld_cc, ld_ben, ir_nzp,
        input  sr1_data, sr2_data, nzp, ben
    );

    // Register-file side
    modport slave (
        input  sr1_sel, sr2_sel, ld_reg, dr_sel, bus_in, ld_cc, ld_ben, ir_nzp,
        output sr1_data, sr2_data, nzp, ben
    );
endinterface

// File: rtl/lc3_cc_gen.sv
// Combinational N/Z/P generator: maps a 16-bit writeback word to a one-hot
// condition code. Shared by every path that can load the CC register.
module lc3_cc_gen
    import lc3_pkg::*;
(
    input  word_t bus_i,
    output nzp_t  nzp_o
);
    logic neg_w;
    logic zero_w;

    // Sign and zero detect; P is whatever is neither, so exactly one bit is set
    always_comb begin
        neg_w         = bus_i[LC3_WORD_W-1];
        zero_w        = (bus_i == '0);
        nzp_o         = '0;
        nzp_o[NZP_N]  = neg_w;
        nzp_o[NZP_Z]  = zero_w;
        nzp_o[NZP_P]  = ~neg_w & ~zero_w;
    end
endmodule

// File: rtl/lc3_regfile.sv
// LC-3 register file R0-R7 with condition-code and BEN registers.
// Optional feature: define LC3_REGFILE_BYPASS_EN to forward bus_in to a read
// port whose address matches dr_sel while ld_reg is high. Only legal when
// bus_in is not combinationally derived from sr1_data/sr2_data.
module lc3_regfile
    import lc3_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    lc3_regfile_if.slave rf
);
    word_t regs_q [LC3_NUM_REGS];
    word_t regs_d [LC3_NUM_REGS];
    nzp_t  nzp_q, nzp_d;
    nzp_t  cc_gen_w;
    logic  ben_q, ben_d;
    word_t sr1_w, sr2_w;

    lc3_cc_gen u_cc_gen (
        .bus_i (rf.bus_in),
        .nzp_o (cc_gen_w)
    );

    // Next state: writeback to R[dr_sel], CC load, BEN from the pre-edge CC
    always_comb begin
        regs_d = regs_q;
        nzp_d  = nzp_q;
        ben_d  = ben_q;
        if (rf.ld_reg) begin
            regs_d[rf.dr_sel] = rf.bus_in;
        end
        if (rf.ld_cc) begin
            nzp_d = cc_gen_w;
        end
        if (rf.ld_ben) begin
            ben_d = |(rf.ir_nzp & nzp_q);
        end
    end

    // State registers; asynchronous reset overrides any concurrent load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LC3_NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            nzp_q <= LC3_CC_RESET;
            ben_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            nzp_q  <= nzp_d;
            ben_q  <= ben_d;
        end
    end

    // Combinational read ports, optionally forwarding the in-flight write
    always_comb begin
        sr1_w = regs_q[rf.sr1_sel];
        sr2_w = regs_q[rf.sr2_sel];
`ifdef LC3_REGFILE_BYPASS_EN
        if (rf.ld_reg && (rf.sr1_sel == rf.dr_sel)) begin
            sr1_w = rf.bus_in;
        end
        if (rf.ld_reg && (rf.sr2_sel == rf.dr_sel)) begin
            sr2_w = rf.bus_in;
        end
`else
`endif
    end

    assign rf.sr1_data = sr1_w;
    assign rf.sr2_data = sr2_w;
    assign rf.nzp      = nzp_q;
    assign rf.ben      = ben_q;

endmodule

// File: tb/tb_lc3_regfile.sv
// Directed testbench for lc3_regfile: table of single-edge vectors plus
// hand-written sequences for same-cycle read-of-write and mid-cycle reset.
module tb_lc3_regfile;

`ifdef LC3_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    lc3_regfile_if rf ();

    lc3_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld_reg;
        logic [2:0]  dr;
        logic [15:0] bus;
        logic        ld_cc;
        logic        ld_ben;
        logic [2:0]  ir;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [2:0]  enzp;
        logic        eben;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rf.ld_reg = 1'b0;
        rf.ld_cc  = 1'b0;
        rf.ld_ben = 1'b0;
        rf.dr_sel = '0;
        rf.bus_in = '0;
        rf.ir_nzp = '0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 8; i += 2) begin
            rf.sr1_sel = 3'(i);
            rf.sr2_sel = 3'(i + 1);
            #1;
            chk($sformatf("%s_r%0d", tag, i), rf.sr1_data, 16'h0000);
            chk($sformatf("%s_r%0d", tag, i + 1), rf.sr2_data, 16'h0000);
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        rf.sr1_sel = '0;
        rf.sr2_sel = '0;
        idle();

        //           ldr dr    bus       ldcc lben ir      s1    s2    e1        e2        enzp    eben
        vecs[0]  = '{1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 3'b000, 3'd3, 3'd5, 16'h1234, 16'h0000, 3'b010, 1'b0};
        vecs[1]  = '{1'b1, 3'd5, 16'hFFFF, 1'b0, 1'b0, 3'b000, 3'd3, 3'd5, 16'h1234, 16'hFFFF, 3'b010, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'b000, 3'd0, 3'd7, 16'h0000, 16'h0000, 3'b010, 1'b0};
        vecs[3]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'b000, 3'd3, 3'd3, 16'h1234, 16'h1234, 3'b010, 1'b0};
        vecs[4]  = '{1'b0, 3'd0, 16'h8000, 1'b1, 1'b0, 3'b000, 3'd5, 3'd4, 16'hFFFF, 16'h0000, 3'b100, 1'b0};
        vecs[5]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'b000, 3'd6, 3'd2, 16'h0000, 16'h0000, 3'b010, 1'b0};
        vecs[6]  = '{1'b0, 3'd0, 16'h7FFF, 1'b1, 1'b0, 3'b000, 3'd1, 3'd3, 16'h0000, 16'h1234, 3'b001, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'b001, 3'd3, 3'd5, 16'h1234, 16'hFFFF, 3'b001, 1'b1};
        vecs[8]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'b010, 3'd3, 3'd5, 16'h1234, 16'hFFFF, 3'b010, 1'b0};
        vecs[9]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'b010, 3'd3, 3'd5, 16'h1234, 16'hFFFF, 3'b010, 1'b1};
        vecs[10] = '{1'b1, 3'd1, 16'h8001, 1'b1, 1'b0, 3'b000, 3'd1, 3'd3, 16'h8001, 16'h1234, 3'b100, 1'b1};
        vecs[11] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'b011, 3'd1, 3'd5, 16'h8001, 16'hFFFF, 3'b100, 1'b0};
        vecs[12] = '{1'b1, 3'd0, 16'h0042, 1'b0, 1'b0, 3'b000, 3'd0, 3'd1, 16'h0042, 16'h8001, 3'b100, 1'b0};
        vecs[13] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'b100, 3'd0, 3'd4, 16'h0042, 16'h0000, 3'b100, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("rst_hold");
        chk("rst_hold_nzp", 16'(rf.nzp), 16'h0002);
        chk("rst_hold_ben", 16'(rf.ben), 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("rst_rel");
        chk("rst_rel_nzp", 16'(rf.nzp), 16'h0002);
        chk("rst_rel_ben", 16'(rf.ben), 16'h0000);

        // Single-edge vectors
        for (int v = 0; v < 14; v++) begin
            @(negedge clk);
            rf.ld_reg  = vecs[v].ld_reg;
            rf.dr_sel  = vecs[v].dr;
            rf.bus_in  = vecs[v].bus;
            rf.ld_cc   = vecs[v].ld_cc;
            rf.ld_ben  = vecs[v].ld_ben;
            rf.ir_nzp  = vecs[v].ir;
            rf.sr1_sel = vecs[v].s1;
            rf.sr2_sel = vecs[v].s2;
            @(posedge clk);
            #1;
            idle();
            #1;
            chk($sformatf("vec%0d_sr1", v), rf.sr1_data, vecs[v].e1);
            chk($sformatf("vec%0d_sr2", v), rf.sr2_data, vecs[v].e2);
            chk($sformatf("vec%0d_nzp", v), 16'(rf.nzp), 16'(vecs[v].enzp));
            chk($sformatf("vec%0d_ben", v), 16'(rf.ben), 16'(vecs[v].eben));
        end

        // Same-cycle read of the register being written
        @(negedge clk);
        rf.ld_reg = 1'b1; rf.dr_sel = 3'd2; rf.bus_in = 16'h0005;
        @(negedge clk);
        rf.ld_reg = 1'b1; rf.dr_sel = 3'd2; rf.bus_in = 16'h00AA;
        rf.sr1_sel = 3'd2; rf.sr2_sel = 3'd3;
        #1;
        chk("row_same_sr1", rf.sr1_data, BYP ? 16'h00AA : 16'h0005);
        chk("row_other_sr2", rf.sr2_data, 16'h1234);
        rf.sr2_sel = 3'd2;
        #1;
        chk("row_same_sr2", rf.sr2_data, BYP ? 16'h00AA : 16'h0005);
        @(posedge clk);
        #1;
        idle();
        #1;
        chk("row_after_sr1", rf.sr1_data, 16'h00AA);
        chk("row_after_sr2", rf.sr2_data, 16'h00AA);
        // Address match without ld_reg must not forward
        rf.dr_sel = 3'd2; rf.bus_in = 16'hFFFF;
        #1;
        chk("row_noload_sr1", rf.sr1_data, 16'h00AA);

        // Asynchronous reset mid-cycle while a write and CC/BEN loads are pending
        @(negedge clk);
        rf.ld_reg = 1'b1; rf.dr_sel = 3'd6; rf.bus_in = 16'h5555;
        rf.ld_cc = 1'b1; rf.ld_ben = 1'b1; rf.ir_nzp = 3'b111;
        rf.sr1_sel = 3'd3; rf.sr2_sel = 3'd5;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sr1", rf.sr1_data, 16'h0000);
        chk("arst_sr2", rf.sr2_data, 16'h0000);
        chk("arst_nzp", 16'(rf.nzp), 16'h0002);
        chk("arst_ben", 16'(rf.ben), 16'h0000);
        @(posedge clk);
        #1;
        rf.sr1_sel = 3'd6;
        rf.ld_reg  = 1'b0;
        #1;
        chk("arst_edge_r6", rf.sr1_data, 16'h0000);
        chk("arst_edge_nzp", 16'(rf.nzp), 16'h0002);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("arst_rel");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
